// File: rtl/mx_exp_max_sequencer.sv
// mx_exp_max_sequencer: shared-exponent max reduction for MX block formation.
//   Each accepted beat of `lanes` exponents is reduced by an unsigned max tree.
//   The per-beat maxima are folded into one running max per block.
//   A block closes after `beats` beats or on an accepted beat with i_last.
//   The block max and the block's beat count are then held on a valid/ready output.
// Latency: o_valid rises on the cycle after the completing beat is accepted.
// Backpressure: o_ready is 1 while accumulating. While a result is held,
//   o_ready follows i_ready, so a consumed result and a new beat can share a cycle.
// Ports: i_clk/i_rst (sync, active-high); i_valid/o_ready/i_exps/i_last (beat in);
//   o_valid/i_ready/o_e_max/o_beats (block result out).
// Optional: define MX_EXP_SPECIAL_EN to add o_special.
//   o_special flags an all-ones (NaN/Inf) exponent seen anywhere in the block.
module mx_exp_max_sequencer #(
  parameter int width = 8,
  parameter int lanes = 8,
  parameter int beats = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [width-1:0]             i_exps [lanes],
  input  logic                         i_last,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [width-1:0]             o_e_max,
  output logic [$clog2(beats+1)-1:0]   o_beats
`ifdef MX_EXP_SPECIAL_EN
  ,
  output logic                         o_special
`endif
);

  localparam int CW = $clog2(beats + 1);
  localparam logic [CW-1:0] BEATS_C = CW'(beats);

  typedef enum logic {ACC, HOLD} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [width-1:0]  run_max, run_max_n;
  logic [width-1:0]  e_max, e_max_n;
  logic [CW-1:0]     nbeats, nbeats_n;

  logic [width-1:0]  tree [lanes];
  logic [width-1:0]  beat_max;
  logic [width-1:0]  acc_max;
  logic [CW-1:0]     cnt_inc;
  logic              take;
  logic              first;
  logic              complete;

  // Pairwise max tree, reduced in place level by level.
  // Slot i at each level reads slots 2i and 2i+1.
  // Those slots are never overwritten before slot i is written, so the in-place update is safe.
  always_comb begin
    tree = i_exps;
    for (int s = lanes / 2; s >= 1; s = s / 2) begin
      for (int i = 0; i < s; i++) begin
        tree[i] = (tree[2*i] > tree[2*i+1]) ? tree[2*i] : tree[2*i+1];
      end
    end
    beat_max = tree[0];
  end

  assign o_valid = (state == HOLD);
  assign o_ready = (state == ACC) || i_ready;
  assign take    = i_valid && o_ready;

  // The count is cleared on completion.
  // A restart from HOLD therefore sees cnt==0, and the same first-beat path serves both states.
  assign first    = (cnt == '0);
  assign cnt_inc  = cnt + CW'(1);
  assign acc_max  = (first || (beat_max > run_max)) ? beat_max : run_max;
  assign complete = take && ((cnt_inc == BEATS_C) || i_last);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    run_max_n = run_max;
    e_max_n   = e_max;
    nbeats_n  = nbeats;
    if (take) begin
      run_max_n = acc_max;
      if (complete) begin
        state_n  = HOLD;
        e_max_n  = acc_max;
        nbeats_n = cnt_inc;
        cnt_n    = '0;
      end else begin
        state_n  = ACC;
        cnt_n    = cnt_inc;
      end
    end else if ((state == HOLD) && i_ready) begin
      state_n = ACC;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ACC;
      cnt     <= '0;
      run_max <= '0;
      e_max   <= '0;
      nbeats  <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      run_max <= run_max_n;
      e_max   <= e_max_n;
      nbeats  <= nbeats_n;
    end
  end

  assign o_e_max = e_max;
  assign o_beats = nbeats;

`ifdef MX_EXP_SPECIAL_EN
  logic beat_sp, acc_sp, run_sp, sp_q;

  always_comb begin
    beat_sp = 1'b0;
    for (int i = 0; i < lanes; i++) begin
      if (i_exps[i] == {width{1'b1}}) beat_sp = 1'b1;
    end
  end

  // The sticky flag restarts on the first beat of each block.
  assign acc_sp = first ? beat_sp : (run_sp | beat_sp);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      run_sp <= 1'b0;
      sp_q   <= 1'b0;
    end else if (take) begin
      run_sp <= acc_sp;
      if (complete) sp_q <= acc_sp;
    end
  end

  assign o_special = sp_q;
`endif

endmodule

// File: tb/tb_mx_exp_max_sequencer.sv
module tb_mx_exp_max_sequencer;

  localparam int LANES = 8;
  localparam int BEATS = 4;
  localparam int CW    = $clog2(BEATS + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          valid = 1'b0;
  logic          last = 1'b0;
  logic          rdy = 1'b1;
  logic [7:0]    exps [LANES];
  logic          o_ready, o_valid;
  logic [7:0]    o_e_max;
  logic [CW-1:0] o_beats;
  logic          b1_ready, b1_valid;
  logic [7:0]    b1_e_max;
  logic [0:0]    b1_beats;
`ifdef MX_EXP_SPECIAL_EN
  logic          o_special, b1_special;
`endif

  mx_exp_max_sequencer #(.width(8), .lanes(LANES), .beats(BEATS)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready),
    .i_exps(exps), .i_last(last), .o_valid(o_valid), .i_ready(rdy),
    .o_e_max(o_e_max), .o_beats(o_beats)
`ifdef MX_EXP_SPECIAL_EN
    , .o_special(o_special)
`endif
  );

  // Single-beat blocks: downstream always ready, so every beat becomes a result.
  mx_exp_max_sequencer #(.width(8), .lanes(LANES), .beats(1)) u_b1 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(b1_ready),
    .i_exps(exps), .i_last(last), .o_valid(b1_valid), .i_ready(1'b1),
    .o_e_max(b1_e_max), .o_beats(b1_beats)
`ifdef MX_EXP_SPECIAL_EN
    , .o_special(b1_special)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the open block is a list of every accepted exponent.
  // A closed block becomes one pending result.
  int blk [$];
  int blk_beats = 0;
  bit pend = 0;
  int pend_max = 0, pend_n = 0;
  bit pend_sp = 0;
  bit b1_v = 0;
  int b1_max = 0;
  bit b1_sp = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs at the falling edge, advance the model, then return 1ns after the rising edge.
  task automatic cycle();
    bit ready_exp;
    int m;
    bit sp;
    @(negedge clk);
    ready_exp = !pend || rdy;
    chk("o_ready", o_ready, ready_exp);
    chk("o_valid", o_valid, pend);
    if (pend) begin
      chk("o_e_max", o_e_max, pend_max);
      chk("o_beats", o_beats, pend_n);
`ifdef MX_EXP_SPECIAL_EN
      chk("o_special", o_special, pend_sp);
`endif
    end
    chk("b1_ready", b1_ready, 1);
    chk("b1_valid", b1_valid, b1_v);
    if (b1_v) begin
      chk("b1_e_max", b1_e_max, b1_max);
      chk("b1_beats", b1_beats, 1);
`ifdef MX_EXP_SPECIAL_EN
      chk("b1_special", b1_special, b1_sp);
`endif
    end
    if (rst) begin
      blk.delete();
      blk_beats = 0;
      pend = 0;
      b1_v = 0;
    end else begin
      if (pend && rdy) pend = 0;
      if (valid && ready_exp) begin
        foreach (exps[i]) blk.push_back(int'(exps[i]));
        blk_beats++;
        if (blk_beats == BEATS || last) begin
          m = 0;
          sp = 0;
          foreach (blk[i]) begin
            if (blk[i] > m) m = blk[i];
            if (blk[i] == 255) sp = 1;
          end
          pend = 1;
          pend_max = m;
          pend_n = blk_beats;
          pend_sp = sp;
          blk.delete();
          blk_beats = 0;
        end
      end
      b1_v = valid;
      if (valid) begin
        b1_max = 0;
        b1_sp = 0;
        foreach (exps[i]) begin
          if (int'(exps[i]) > b1_max) b1_max = int'(exps[i]);
          if (exps[i] == 8'hFF) b1_sp = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Random lanes no larger than m, with exactly one lane forced to m.
  task automatic set_lanes(input int m);
    foreach (exps[i]) exps[i] = 8'($urandom_range(0, m));
    exps[$urandom_range(0, LANES - 1)] = 8'(m);
  endtask

  task automatic drive(input int m, input bit v, input bit l);
    valid = v;
    last = l;
    set_lanes(m);
    cycle();
  endtask

  initial begin
    foreach (exps[i]) exps[i] = 8'd0;
    @(posedge clk);
    #1;
    cycle();
    rst = 1'b0;
    chk("reset_valid", o_valid, 0);
    chk("reset_emax", o_e_max, 0);
    chk("reset_beats", o_beats, 0);
    chk("reset_ready", o_ready, 1);

    // Full block of four beats.
    valid = 1'b1;
    last = 1'b0;
    foreach (exps[i]) exps[i] = 8'd0;
    exps[0] = 8'd3; exps[1] = 8'd7; exps[2] = 8'd1;
    cycle();
    drive(12, 1, 0);
    drive(5, 1, 0);
    drive(9, 1, 0);
    chk("full_valid", o_valid, 1);
    chk("full_emax", o_e_max, 12);
    chk("full_beats", o_beats, 4);
    drive(0, 0, 0);
    chk("full_valid_once", o_valid, 0);

    // Short block closed by i_last; the following block must restart its max.
    drive(20, 1, 0);
    drive(17, 1, 1);
    chk("short_emax", o_e_max, 20);
    chk("short_beats", o_beats, 2);
    drive(4, 1, 0);
    drive(3, 1, 1);
    chk("restart_emax", o_e_max, 4);
    chk("restart_beats", o_beats, 2);
    drive(0, 0, 0);

    // Back-pressure: hold the result for five cycles, then release with a beat.
    rdy = 1'b0;
    drive(30, 1, 0);
    drive(60, 1, 0);
    drive(45, 1, 0);
    drive(10, 1, 0);
    repeat (5) drive(99, 1, 0);
    chk("bp_ready", o_ready, 0);
    chk("bp_emax", o_e_max, 60);
    chk("bp_beats", o_beats, 4);
    rdy = 1'b1;
    drive(77, 1, 0);
    chk("bp_release_valid", o_valid, 0);
    drive(5, 1, 0);
    drive(6, 1, 0);
    drive(1, 1, 0);
    chk("bp_next_emax", o_e_max, 77);
    chk("bp_next_beats", o_beats, 4);

    // Streaming: sixteen back-to-back beats give one result every fourth cycle.
    for (int i = 0; i < 16; i++) begin
      drive($urandom_range(0, 254), 1, 0);
      chk("stream_valid", o_valid, (i % 4 == 3) ? 1 : 0);
    end
    drive(0, 0, 0);

    // Random traffic with random back-pressure, short blocks and all-ones exponents.
    for (int n = 0; n < 300; n++) begin
      rdy = ($urandom_range(0, 9) < 7);
      valid = ($urandom_range(0, 9) < 8);
      last = ($urandom_range(0, 7) == 0);
      foreach (exps[i]) exps[i] = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
      cycle();
    end
    rdy = 1'b1;
    drive(0, 0, 0);
    drive(0, 0, 0);
    // Ensure no block is left open before the reset test.
    drive(1, 1, 1);
    drive(0, 0, 0);

    // Reset mid-block discards the partial max of 200.
    drive(200, 1, 0);
    drive(200, 1, 0);
    rst = 1'b1;
    valid = 1'b0;
    cycle();
    rst = 1'b0;
    chk("rst_valid", o_valid, 0);
    drive(10, 1, 0);
    drive(10, 1, 0);
    drive(10, 1, 0);
    drive(10, 1, 0);
    chk("rst_emax", o_e_max, 10);
    chk("rst_beats", o_beats, 4);
    chk("b1_beats_one", b1_beats, 1);
    drive(0, 0, 0);

`ifdef MX_EXP_SPECIAL_EN
    drive(1, 1, 0);
    drive(2, 1, 0);
    drive(255, 1, 0);
    drive(3, 1, 0);
    chk("special_set", o_special, 1);
    repeat (4) drive(100, 1, 0);
    chk("special_clear", o_special, 0);
    drive(0, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mx_exp_max_sequencer.md
Name: mx_exp_max_sequencer

Overview:
- Streaming controller that sequences the shared-exponent max reduction for MX block formation.
- Accepts exponent beats of LANES values per cycle and reduces each beat with a lane-wise unsigned max tree.
- Accumulates the per-beat maxima over one MX block of up to BEATS beats, then presents the block's maximum exponent on a valid/ready output.
- Sits between the element unpacker and the shared-scale / element-quantise stage.

Parameters:
- width, 8, exponent bit width (unsigned).
- lanes, 8, exponents accepted per beat; power of two, at least 1.
- beats, 4, beats per full MX block; at least 1. Block length = lanes*beats (32 by default).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  input beat valid.
- o_ready  output  1  sequencer can accept a beat.
- i_exps  input  width x lanes  unpacked array of unsigned exponents for the beat.
- i_last  input  1  beat is the final beat of a short block; sampled only on an accepted beat.
- o_valid  output  1  block result valid.
- i_ready  input  1  downstream accepts the result.
- o_e_max  output  width  maximum exponent of the completed block.
- o_beats  output  $clog2(beats+1)  number of beats that formed the result.

Behaviour:
- Reset: takes effect at the clock edge while i_rst=1.
  - Reset state: state=ACC, beat count=0, running max=0, o_valid=0, o_e_max=0, o_beats=0.
  - Reset mid-block discards partial accumulation; reset while o_valid=1 drops the pending result.
- Beat max: combinational unsigned max over i_exps. Ties are irrelevant because only the value is output. No arithmetic overflow is possible.
- Accept: a beat is accepted when i_valid && o_ready.
- State ACC:
  - o_ready=1, o_valid=0.
  - On accept with count==0: running max = beat max.
  - On any other accept: running max = max(running, beat max).
  - Count increments on every accept.
  - Block completes on an accepted beat when count+1==beats or i_last=1. On completion, next state is HOLD, o_e_max = final max, o_beats = count+1, and the count clears.
  - i_last on the beats-th beat gives a single completion, not two.
- State HOLD:
  - o_valid=1; o_ready = i_ready (ready passes through from downstream).
  - i_ready=1 with i_valid=0: result consumed, next state ACC.
  - i_ready=1 with i_valid=1: result consumed and the beat starts a new block with count=1 and running max = beat max. If that beat completes the block (beats==1 or i_last), stay in HOLD with the new result; otherwise go to ACC.
  - i_ready=0: o_e_max and o_beats stay stable and o_valid stays 1 (no data change while stalled).
- Latency: o_valid rises on the cycle after the completing beat is accepted.
- Throughput: one beat per cycle with no bubbles while i_ready is held high; one result per block.
- i_exps and i_last are ignored on cycles without an accept.
- Single running-max register; no internal pipelining of the max tree. Critical path = log2(lanes) compare levels plus one compare.

Optional Feature:
- Macro: MX_EXP_SPECIAL_EN.
- When defined:
  - Adds output o_special (1 bit), reset 0.
  - o_special is set when any accepted exponent in the block equals all-ones (2^width-1, the NaN/Inf encoding).
  - It is sticky across the block and presented alongside o_e_max with the same valid/hold rules.
  - It clears when the next block starts.
- When undefined: no port, no logic; behaviour is otherwise identical.

Test Plan:
- Full block: 4 beats with lane values {3,7,1,0,...}, {12,...}, {5,...}, {9,...} and i_ready=1 → o_valid for exactly 1 cycle, one cycle after beat 4; o_e_max=12, o_beats=4.
- Short block: i_last on beat 2, with beat maxima 20 then 17 → o_e_max=20, o_beats=2. The next block restarts its count; a following maximum of 4 yields 4, not 20.
- Back-pressure: i_ready=0 for 5 cycles after completion → o_e_max and o_beats stable and o_ready=0. Release with i_valid=1 → result consumed and the new beat is accepted in the same cycle; next result is correct.
- Streaming: 16 continuous beats with i_ready=1 → 4 results on cycles 5, 9, 13 and 17 relative to the first beat, with no stall. A random-vector comparison against a reference max matches.
- Reset mid-block: 2 beats with max 200, i_rst for 1 cycle, then 4 beats with max 10 → o_e_max=10. During reset o_valid=0.
- MX_EXP_SPECIAL_EN defined: one lane=255 in beat 3 → o_special=1 with the result. The next block without 255 gives o_special=0. A beats=1 build completes every beat with o_beats=1.
